// File: rtl/add_sequencer.sv
// add_sequencer: nibble-serial 32-bit add/subtract, one 4-bit slice per clock, with request/result handshake
module add_sequencer #(
  parameter int NIB = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op_sub,
  input  logic        cin,
  output logic        res_valid,
  input  logic        res_ack,
  output logic [31:0] sum,
  output logic        cout,
  output logic        zero,
  output logic        ovf,
  output logic        neg,
  output logic        busy
);
  localparam int STEPS = 32 / NIB;
  localparam int KW = $clog2(STEPS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d, neg_q, neg_d;
  logic [KW-1:0] k_q, k_d;
  logic [NIB-1:0] na, nb;
  logic [NIB:0] slice;
  logic res_valid_q, req_ready_q, busy_q;
  always_comb begin
    na = a_q[k_q*NIB +: NIB];
    nb = b_q[k_q*NIB +: NIB];
    slice = {1'b0, na} + {1'b0, nb} + {{NIB{1'b0}}, carry_q};
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    k_d = k_q;
    cout_d = cout_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    neg_d = neg_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = a;
        b_d = b ^ {32{op_sub}};
        carry_d = op_sub | cin;
        k_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[k_q*NIB +: NIB] = slice[NIB-1:0];
        carry_d = slice[NIB];
        k_d = k_q + 1'b1;
        if (k_q == KW'(STEPS - 1)) begin
          state_d = DONE;
          cout_d = slice[NIB];
          ovf_d = a_q[31] ^ b_q[31] ^ slice[NIB-1] ^ slice[NIB];
          zero_d = sum_d == 32'd0;
          neg_d = sum_d[31];
        end
      end
      DONE: state_d = res_ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      k_q <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
      ovf_q <= 1'b0;
      neg_q <= 1'b0;
      res_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      k_q <= k_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      neg_q <= neg_d;
      res_valid_q <= state_d == DONE;
      req_ready_q <= state_d == IDLE;
      busy_q <= state_d == RUN;
    end
  end
  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign busy = busy_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign ovf = ovf_q;
  assign neg = neg_q;
endmodule

// File: tb/tb_add_sequencer.sv
// tb_add_sequencer: randomized and directed self-checking bench for add_sequencer against an arithmetic reference model
module tb_add_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, op_sub = 1'b0, cin = 1'b0, res_ack = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic req_ready, res_valid, cout, zero, ovf, neg, busy;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  add_sequencer #(.NIB(4)) dut (
    .clk(clk), .rst(rst), .start(start), .req_ready(req_ready), .a(a), .b(b),
    .op_sub(op_sub), .cin(cin), .res_valid(res_valid), .res_ack(res_ack), .sum(sum),
    .cout(cout), .zero(zero), .ovf(ovf), .neg(neg), .busy(busy)
  );
  task automatic model(input logic [31:0] x, y, input logic sub, ci,
                       output logic [31:0] s, output logic c, o, z, n);
    longint u, sv;
    u = sub ? longint'({32'b0, x}) - longint'({32'b0, y}) : longint'({32'b0, x}) + longint'({32'b0, y}) + longint'(ci);
    sv = sub ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    s = u[31:0];
    c = sub ? (x >= y) : u[32];
    o = sv != longint'($signed(s));
    z = s == 32'd0;
    n = s[31];
  endtask
  task automatic run_op(input logic [31:0] x, y, input logic sub, ci, output int lat);
    @(negedge clk);
    a = x;
    b = y;
    op_sub = sub;
    cin = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op_sub = 1'($urandom);
    cin = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got=%b exp=1", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid got=%b exp=0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (sum !== 32'd0) begin errors++; $display("FAIL reset sum got=%h exp=0", sum); end
    checks++; if ({cout, zero, ovf, neg} !== 4'b0100) begin errors++; $display("FAIL reset flags got=%b exp=0100", {cout, zero, ovf, neg}); end
  endtask
  task automatic test_directed;
    logic [31:0] va[6], vb[6], vs[6], es;
    logic vop[6], vci[6], ec, eo, ez, en;
    int lat;
    va = '{32'h0000_000F, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7, 32'h1234_5678};
    vb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd7, 32'd5, 32'h0FED_CBA9};
    vop = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vci = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vs = '{32'h0000_0010, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0000_0002, 32'h2222_2222};
    for (int i = 0; i < 6; i++) begin
      model(va[i], vb[i], vop[i], vci[i], es, ec, eo, ez, en);
      run_op(va[i], vb[i], vop[i], vci[i], lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL dir%0d latency got=%0d exp=8", i, lat); end
      checks++; if (sum !== vs[i]) begin errors++; $display("FAIL dir%0d sum got=%h exp=%h", i, sum, vs[i]); end
      checks++; if (cout !== ec) begin errors++; $display("FAIL dir%0d cout got=%b exp=%b", i, cout, ec); end
      checks++; if (zero !== ez) begin errors++; $display("FAIL dir%0d zero got=%b exp=%b", i, zero, ez); end
      checks++; if (ovf !== eo) begin errors++; $display("FAIL dir%0d ovf got=%b exp=%b", i, ovf, eo); end
      checks++; if (neg !== en) begin errors++; $display("FAIL dir%0d neg got=%b exp=%b", i, neg, en); end
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      checks++; if ({req_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL dir%0d ack ready/valid got=%b exp=10", i, {req_ready, res_valid}); end
    end
  endtask
  task automatic test_hold_and_back_to_back;
    logic [31:0] x1, y1, x2, y2, es, es2;
    logic ec, eo, ez, en;
    int lat;
    x1 = $urandom;
    y1 = $urandom;
    x2 = $urandom;
    y2 = $urandom;
    model(x1, y1, 1'b0, 1'b1, es, ec, eo, ez, en);
    @(negedge clk);
    a = x1;
    b = y1;
    op_sub = 1'b0;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++; if ({req_ready, busy, res_valid} !== 3'b010) begin errors++; $display("FAIL hold run%0d ready/busy/valid got=%b exp=010", i, {req_ready, busy, res_valid}); end
      a = $urandom;
      b = $urandom;
      op_sub = 1'($urandom);
      cin = 1'($urandom);
      res_ack = (i == 3);
      @(negedge clk);
    end
    res_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({req_ready, busy, res_valid} !== 3'b001) begin errors++; $display("FAIL hold done%0d ready/busy/valid got=%b exp=001", i, {req_ready, busy, res_valid}); end
      checks++; if ({sum, cout, ovf, zero, neg} !== {es, ec, eo, ez, en}) begin errors++; $display("FAIL hold done%0d result got=%h/%b exp=%h/%b", i, sum, {cout, ovf, zero, neg}, es, {ec, eo, ez, en}); end
      if (i < 4) @(negedge clk);
    end
    a = x2;
    b = y2;
    op_sub = 1'b1;
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    checks++; if ({req_ready, busy, res_valid} !== 3'b100) begin errors++; $display("FAIL b2b idle ready/busy/valid got=%b exp=100", {req_ready, busy, res_valid}); end
    @(negedge clk);
    start = 1'b0;
    checks++; if ({req_ready, busy} !== 2'b01) begin errors++; $display("FAIL b2b accept ready/busy got=%b exp=01", {req_ready, busy}); end
    a = $urandom;
    b = $urandom;
    model(x2, y2, 1'b1, 1'b0, es2, ec, eo, ez, en);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b latency got=%0d exp=8", lat); end
    checks++; if ({sum, cout, ovf, zero, neg} !== {es2, ec, eo, ez, en}) begin errors++; $display("FAIL b2b result got=%h/%b exp=%h/%b", sum, {cout, ovf, zero, neg}, es2, {ec, eo, ez, en}); end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask
  task automatic test_reset_mid_run;
    logic [31:0] es;
    logic ec, eo, ez, en;
    int lat;
    @(negedge clk);
    a = 32'hDEAD_BEEF;
    b = 32'h1111_1111;
    op_sub = 1'b0;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({req_ready, busy, res_valid} !== 3'b100) begin errors++; $display("FAIL midrst ready/busy/valid got=%b exp=100", {req_ready, busy, res_valid}); end
    checks++; if (sum !== 32'd0) begin errors++; $display("FAIL midrst sum got=%h exp=0", sum); end
    checks++; if ({cout, zero, ovf, neg} !== 4'b0100) begin errors++; $display("FAIL midrst flags got=%b exp=0100", {cout, zero, ovf, neg}); end
    model(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b1, es, ec, eo, ez, en);
    run_op(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b1, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst fresh latency got=%0d exp=8", lat); end
    checks++; if ({sum, cout, ovf, zero, neg} !== {es, ec, eo, ez, en}) begin errors++; $display("FAIL midrst fresh result got=%h/%b exp=%h/%b", sum, {cout, ovf, zero, neg}, es, {ec, eo, ez, en}); end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask
  task automatic test_random;
    logic [31:0] x, y, es;
    logic sub, ci, ec, eo, ez, en;
    int lat, d;
    for (int i = 0; i < 30; i++) begin
      x = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      y = ($urandom_range(0, 4) == 0) ? x : $urandom;
      sub = 1'($urandom);
      ci = 1'($urandom);
      model(x, y, sub, ci, es, ec, eo, ez, en);
      run_op(x, y, sub, ci, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL rnd%0d latency got=%0d exp=8", i, lat); end
      checks++; if ({sum, cout, ovf, zero, neg} !== {es, ec, eo, ez, en}) begin errors++; $display("FAIL rnd%0d result a=%h b=%h sub=%b cin=%b got=%h/%b exp=%h/%b", i, x, y, sub, ci, sum, {cout, ovf, zero, neg}, es, {ec, eo, ez, en}); end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      checks++; if ({res_valid, sum} !== {1'b1, es}) begin errors++; $display("FAIL rnd%0d hold valid/sum got=%b/%h exp=1/%h", i, res_valid, sum, es); end
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      checks++; if ({req_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL rnd%0d ack ready/valid got=%b exp=10", i, {req_ready, res_valid}); end
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_hold_and_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
